// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive parser.
// Contents:
//   state_t         frame-state FSM encoding
//   *_OFS           byte offsets into the Ethernet II + IPv4 + UDP header
//   HDR_LEN         total header length stripped from every frame
//   ETHERTYPE_IPV4  / IP_PROTO_UDP  accepted protocol identifiers
//   csum_add        16-bit one's-complement addition with end-around carry
package udp_rx_pkg;

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        IDLE    = 3'd1,
        HDR     = 3'd2,
        PAYLOAD = 3'd3,
        DROP    = 3'd4
    } state_t;

    localparam logic [5:0] ETH_TYPE_OFS = 6'd12;
    localparam logic [5:0] IP_VER_OFS   = 6'd14;
    localparam logic [5:0] IP_PROTO_OFS = 6'd23;
    localparam logic [5:0] IP_SRC_OFS   = 6'd26;
    localparam logic [5:0] IP_DST_OFS   = 6'd30;
    localparam logic [5:0] UDP_SRC_OFS  = 6'd34;
    localparam logic [5:0] UDP_DST_OFS  = 6'd36;
    localparam logic [5:0] UDP_LEN_OFS  = 6'd38;
    localparam logic [5:0] HDR_LEN      = 6'd42;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    // The carry out of bit 15 is added back in; the result cannot overflow
    // again because the largest 17-bit sum is 0x1FFFE.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/udp_rx_parser_ip_csum_acc.sv
// Byte-serial IPv4 header checksum accumulator.
// Bytes arrive high byte first; every second byte completes a 16-bit word.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start        marks the first (high) byte of the summed region; clears the sum
//   byte_valid   data holds a byte of the summed region
//   data         header byte
//   sum          running sum including the word completed by the current
//                byte; meaningful only when the current byte is a low byte
module ip_csum_acc
    import udp_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  data,
    output logic [15:0] sum
);

    logic [15:0] acc;
    logic [7:0]  hi;
    logic        have_hi;

    assign sum = csum_add(acc, {hi, data});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= 16'd0;
            hi      <= 8'd0;
            have_hi <= 1'b0;
        end else if (byte_valid) begin
            if (start || !have_hi) begin
                hi      <= data;
                have_hi <= 1'b1;
                if (start) begin
                    acc <= 16'd0;
                end
            end else begin
                acc     <= csum_add(acc, {hi, data});
                have_hi <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/udp_rx_parser.sv
// UDP receive parser: consumes the byte-wide MAC rx stream, checks the
// Ethernet II / IPv4 / UDP header against the local MAC, IP and port,
// strips the 42-byte header and forwards only the UDP payload.
//
// Handshake: neither stream has a ready signal. A beat is transferred on
// every clock edge where tvalid is high; the source never stalls and the
// sink must accept every beat. tuser is meaningful only together with tlast.
//
// Ports:
//   gtx_clk, glbl_rst            clock, asynchronous active-high reset
//   rx_axis_*                    MAC rx stream (tuser = bad frame, with tlast)
//   m_axis_*                     payload stream (tuser = MAC bad or truncated)
//   hdr_valid                    one-cycle pulse per accepted header
//   src_ip/src_port/payload_len  metadata, stable until the next hdr_valid
//   good_cnt/drop_cnt            saturating frame statistics
//
// Build option: define UDP_RX_IP_CSUM_CHECK_EN to also drop frames whose
// IPv4 header checksum is wrong.
module udp_rx_parser
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A35000102,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80102,
    parameter logic [15:0] LOCAL_PORT = 16'd5000,
    parameter int          CNT_W      = 16
) (
    input  logic             gtx_clk,
    input  logic             glbl_rst,
    input  logic [7:0]       rx_axis_tdata,
    input  logic             rx_axis_tvalid,
    input  logic             rx_axis_tlast,
    input  logic             rx_axis_tuser,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             hdr_valid,
    output logic [31:0]      src_ip,
    output logic [15:0]      src_port,
    output logic [15:0]      payload_len,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      state, state_d;
    logic [5:0]  cnt;           // index of the next header byte while in HDR
    logic [5:0]  hidx;          // header index of the current beat
    logic [39:0] sh;            // last five header bytes, newest in [7:0]
    logic [31:0] src_ip_cap;
    logic [15:0] src_port_cap;
    logic [15:0] plen_cap;
    logic [15:0] pcnt;          // payload bytes taken into the hold register
    logic [7:0]  hold;
    logic        hold_v;
    logic        flush_v;       // second beat of a two-cycle end-of-frame flush
    logic [7:0]  flush_d;
    logic        flush_u;

    logic        hdr_beat;
    logic        chk_fail;
    logic        pay_done;
    logic        pay_final;
    logic        hdr_accept;
    logic        inc_good;
    logic        inc_drop;
    logic        load_hold;
    logic        flush_set;
    logic        flush_u_d;
    logic        o_v;
    logic [7:0]  o_d;
    logic        o_l;
    logic        o_u;

    assign hdr_beat  = rx_axis_tvalid && (state == IDLE || state == HDR);
    assign hidx      = (state == IDLE) ? 6'd0 : cnt;
    assign pay_done  = (pcnt == plen_cap);
    assign pay_final = ((pcnt + 16'd1) == plen_cap);

`ifdef UDP_RX_IP_CSUM_CHECK_EN
    logic [15:0] csum_sum;
    logic        csum_start;
    logic        csum_byte;

    assign csum_start = hdr_beat && (hidx == IP_VER_OFS);
    assign csum_byte  = hdr_beat && (hidx >= IP_VER_OFS) && (hidx <= IP_DST_OFS + 6'd3);

    ip_csum_acc u_csum (
        .clk        (gtx_clk),
        .rst        (glbl_rst),
        .start      (csum_start),
        .byte_valid (csum_byte),
        .data       (rx_axis_tdata),
        .sum        (csum_sum)
    );
`endif

    // Each check fires on the last byte of its field, using the shift
    // register for the earlier bytes of that field.
    always_comb begin
        chk_fail = 1'b0;
        case (hidx)
            6'd5:                chk_fail = !(({sh, rx_axis_tdata} == LOCAL_MAC) ||
                                              ({sh, rx_axis_tdata} == 48'hFFFF_FFFF_FFFF));
            ETH_TYPE_OFS + 6'd1: chk_fail = ({sh[7:0], rx_axis_tdata} != ETHERTYPE_IPV4);
            IP_VER_OFS:          chk_fail = (rx_axis_tdata != 8'h45);
            IP_PROTO_OFS:        chk_fail = (rx_axis_tdata != IP_PROTO_UDP);
            IP_DST_OFS + 6'd3:   chk_fail = ({sh[23:0], rx_axis_tdata} != LOCAL_IP);
            UDP_DST_OFS + 6'd1:  chk_fail = ({sh[7:0], rx_axis_tdata} != LOCAL_PORT);
            UDP_LEN_OFS + 6'd1:  chk_fail = ({sh[7:0], rx_axis_tdata} < 16'd8);
            default:             chk_fail = 1'b0;
        endcase
`ifdef UDP_RX_IP_CSUM_CHECK_EN
        if (hidx == IP_DST_OFS + 6'd3 && csum_sum != 16'hFFFF) begin
            chk_fail = 1'b1;
        end
`endif
    end

    always_ff @(posedge gtx_clk or posedge glbl_rst) begin
        if (glbl_rst) begin
            state <= SYNC;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        hdr_accept = 1'b0;
        inc_good   = 1'b0;
        inc_drop   = 1'b0;
        load_hold  = 1'b0;
        flush_set  = 1'b0;
        flush_u_d  = 1'b0;
        // A pending flush beat owns the output; no other emission can
        // coincide because the next frame is still in its header.
        o_v = flush_v;
        o_d = flush_d;
        o_l = flush_v;
        o_u = flush_v & flush_u;
        case (state)
            SYNC: begin
                if (rx_axis_tvalid && rx_axis_tlast) state_d = IDLE;
            end
            IDLE, HDR: begin
                if (rx_axis_tvalid) begin
                    if (chk_fail) begin
                        inc_drop = 1'b1;
                        state_d  = rx_axis_tlast ? IDLE : DROP;
                    end else if (hidx == HDR_LEN - 6'd1) begin
                        hdr_accept = 1'b1;
                        if (plen_cap == 16'd0) begin
                            inc_good = 1'b1;
                            state_d  = rx_axis_tlast ? IDLE : DROP;
                        end else if (rx_axis_tlast) begin
                            // Header complete but no payload byte at all.
                            inc_drop = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else if (rx_axis_tlast) begin
                        inc_drop = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_axis_tvalid) begin
                    if (!pay_done) begin
                        if (hold_v) begin
                            o_v = 1'b1;
                            o_d = hold;
                            o_l = 1'b0;
                            o_u = 1'b0;
                        end
                        if (rx_axis_tlast) begin
                            // Final payload byte or truncation: the held byte
                            // goes out now, the tlast byte one cycle later.
                            if (hold_v) begin
                                flush_set = 1'b1;
                                flush_u_d = pay_final ? rx_axis_tuser : 1'b1;
                            end else begin
                                o_v = 1'b1;
                                o_d = rx_axis_tdata;
                                o_l = 1'b1;
                                o_u = pay_final ? rx_axis_tuser : 1'b1;
                            end
                            inc_good = pay_final;
                            inc_drop = !pay_final;
                            state_d  = IDLE;
                        end else begin
                            load_hold = 1'b1;
                        end
                    end else if (rx_axis_tlast) begin
                        // End of padding: release the held final byte.
                        o_v      = 1'b1;
                        o_d      = hold;
                        o_l      = 1'b1;
                        o_u      = rx_axis_tuser;
                        inc_good = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            DROP: begin
                if (rx_axis_tvalid && rx_axis_tlast) state_d = IDLE;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge gtx_clk or posedge glbl_rst) begin
        if (glbl_rst) begin
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            hdr_valid     <= 1'b0;
            src_ip        <= 32'd0;
            src_port      <= 16'd0;
            payload_len   <= 16'd0;
            good_cnt      <= '0;
            drop_cnt      <= '0;
            cnt           <= 6'd0;
            sh            <= 40'd0;
            src_ip_cap    <= 32'd0;
            src_port_cap  <= 16'd0;
            plen_cap      <= 16'd0;
            pcnt          <= 16'd0;
            hold          <= 8'd0;
            hold_v        <= 1'b0;
            flush_v       <= 1'b0;
            flush_d       <= 8'd0;
            flush_u       <= 1'b0;
        end else begin
            m_axis_tvalid <= o_v;
            m_axis_tlast  <= o_l;
            m_axis_tuser  <= o_u;
            if (o_v) m_axis_tdata <= o_d;
            hdr_valid <= hdr_accept;

            flush_v <= flush_set;
            if (flush_set) begin
                flush_d <= rx_axis_tdata;
                flush_u <= flush_u_d;
            end

            if (hdr_beat) begin
                sh  <= {sh[31:0], rx_axis_tdata};
                cnt <= (state == IDLE) ? 6'd1 : cnt + 6'd1;
                if (hidx == IP_SRC_OFS + 6'd3)  src_ip_cap   <= {sh[23:0], rx_axis_tdata};
                if (hidx == UDP_SRC_OFS + 6'd1) src_port_cap <= {sh[7:0], rx_axis_tdata};
                if (hidx == UDP_LEN_OFS + 6'd1) plen_cap     <= {sh[7:0], rx_axis_tdata} - 16'd8;
            end

            if (hdr_accept) begin
                src_ip      <= src_ip_cap;
                src_port    <= src_port_cap;
                payload_len <= plen_cap;
                pcnt        <= 16'd0;
                hold_v      <= 1'b0;
            end

            if (load_hold) begin
                hold   <= rx_axis_tdata;
                hold_v <= 1'b1;
                pcnt   <= pcnt + 16'd1;
            end

            if (inc_good && good_cnt != CNT_MAX) good_cnt <= good_cnt + CNT_ONE;
            if (inc_drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
module tb_udp_rx_parser;

    localparam logic [47:0] LOCAL_MAC  = 48'h000A35000102;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A80102;
    localparam logic [15:0] LOCAL_PORT = 16'd5000;

    // ---------------- clock / reset ----------------
    logic        gtx_clk = 1'b0;
    logic        glbl_rst = 1'b1;
    logic [7:0]  rx_axis_tdata = 8'd0;
    logic        rx_axis_tvalid = 1'b0;
    logic        rx_axis_tlast = 1'b0;
    logic        rx_axis_tuser = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        hdr_valid;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] payload_len;
    logic [15:0] good_cnt;
    logic [15:0] drop_cnt;

    always #4 gtx_clk = ~gtx_clk;

    udp_rx_parser dut (
        .gtx_clk        (gtx_clk),
        .glbl_rst       (glbl_rst),
        .rx_axis_tdata  (rx_axis_tdata),
        .rx_axis_tvalid (rx_axis_tvalid),
        .rx_axis_tlast  (rx_axis_tlast),
        .rx_axis_tuser  (rx_axis_tuser),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .hdr_valid      (hdr_valid),
        .src_ip         (src_ip),
        .src_port       (src_port),
        .payload_len    (payload_len),
        .good_cnt       (good_cnt),
        .drop_cnt       (drop_cnt)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [9:0]  exp_q[$];   // {tuser, tlast, tdata}
    logic [63:0] hdr_q[$];   // {src_ip, src_port, payload_len}
    int          good_exp = 0;
    int          drop_exp = 0;
    logic [7:0]  frm[$];
    logic [7:0]  pay[$];
    longint      t_in = 0;
    longint      t_out = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge gtx_clk) begin
        logic [9:0]  e;
        logic [63:0] h;
        if (!glbl_rst && m_axis_tvalid) begin
            if (m_axis_tlast) t_out = $time;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h, expected no beat",
                         {m_axis_tuser, m_axis_tlast, m_axis_tdata});
            end else begin
                e = exp_q.pop_front();
                check("payload_beat", {54'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {54'd0, e});
            end
        end
        if (!glbl_rst && hdr_valid) begin
            if (hdr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_hdr: got %0h, expected no header", {src_ip, src_port, payload_len});
            end else begin
                h = hdr_q.pop_front();
                check("hdr_meta", {src_ip, src_port, payload_len}, h);
            end
        end
    end

    // ---------------- frame builder ----------------
    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                               input logic [31:0] dip, input logic [15:0] dport,
                               input logic [15:0] udp_len, input int npad,
                               input logic [31:0] sip, input logic [15:0] sport);
        logic [15:0] tot;
        logic [15:0] c;
        int          s;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
        frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
        tot = udp_len + 16'd20;
        frm.push_back(8'h45); frm.push_back(8'h00);
        frm.push_back(tot[15:8]); frm.push_back(tot[7:0]);
        frm.push_back(8'($urandom_range(0, 255))); frm.push_back(8'($urandom_range(0, 255)));
        frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'h11);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frm.push_back(sip[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(dip[i*8 +: 8]);
        frm.push_back(sport[15:8]); frm.push_back(sport[7:0]);
        frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
        frm.push_back(udp_len[15:8]); frm.push_back(udp_len[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        foreach (pay[i]) frm.push_back(pay[i]);
        repeat (npad) frm.push_back(8'h00);
        s = 0;
        for (int i = 14; i < 34; i += 2) s += int'({frm[i], frm[i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        c = ~(16'(s));
        frm[24] = c[15:8];
        frm[25] = c[7:0];
    endtask

    // ---------------- reference model ----------------
    task automatic model_frame(input logic u);
        int          n;
        int          avail;
        int          k;
        int          s;
        logic        ok;
        logic [47:0] mac;
        logic [15:0] ulen;
        logic [15:0] plen;
        n = frm.size();
        if (n < 42) begin
            drop_exp++;
            return;
        end
        mac  = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        ulen = {frm[38], frm[39]};
        ok = (mac == LOCAL_MAC) || (mac == 48'hFFFF_FFFF_FFFF);
        ok = ok && ({frm[12], frm[13]} == 16'h0800);
        ok = ok && (frm[14] == 8'h45);
        ok = ok && (frm[23] == 8'h11);
        ok = ok && ({frm[30], frm[31], frm[32], frm[33]} == LOCAL_IP);
        ok = ok && ({frm[36], frm[37]} == LOCAL_PORT);
        ok = ok && (ulen >= 16'd8);
`ifdef UDP_RX_IP_CSUM_CHECK_EN
        s = 0;
        for (int i = 14; i < 34; i += 2) s += int'({frm[i], frm[i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        ok = ok && (s == 32'hFFFF);
`else
        s = 0;
`endif
        if (!ok) begin
            drop_exp++;
            return;
        end
        plen = ulen - 16'd8;
        hdr_q.push_back({frm[26], frm[27], frm[28], frm[29], frm[34], frm[35], plen});
        avail = n - 42;
        if (plen == 16'd0) begin
            good_exp++;
        end else if (avail == 0) begin
            drop_exp++;
        end else begin
            k = (avail < int'(plen)) ? avail : int'(plen);
            for (int i = 0; i < k; i++) begin
                if (i == k - 1)
                    exp_q.push_back({(avail < int'(plen)) ? 1'b1 : u, 1'b1, frm[42+i]});
                else
                    exp_q.push_back({1'b0, 1'b0, frm[42+i]});
            end
            if (avail < int'(plen)) drop_exp++;
            else good_exp++;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic beat(input logic [7:0] d, input logic l, input logic u);
        @(posedge gtx_clk);
        #1;
        rx_axis_tvalid = 1'b1;
        rx_axis_tdata  = d;
        rx_axis_tlast  = l;
        rx_axis_tuser  = u;
        if (l) t_in = $time;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge gtx_clk);
            #1;
            rx_axis_tvalid = 1'b0;
            rx_axis_tlast  = 1'b0;
            rx_axis_tuser  = 1'b0;
        end
    endtask

    // gap_mode 0: back-to-back, 1: every other cycle, 2: random gaps
    task automatic send_frame(input int gap_mode, input logic u);
        int n;
        model_frame(u);
        n = frm.size();
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1 && i > 0) idle(1);
            if (gap_mode == 2) idle($urandom_range(0, 2));
            beat(frm[i], i == n - 1, (i == n - 1) ? u : 1'b0);
        end
        idle(6);
        check("good_cnt", 64'(good_cnt), 64'(good_exp));
        check("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
    endtask

    task automatic set_pay_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_reset_state();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tuser", 64'(m_axis_tuser), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        check("rst_meta", {src_ip, src_port, payload_len}, 64'd0);
        check("rst_good_cnt", 64'(good_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [47:0] dmac;
        logic [15:0] etype;
        logic [31:0] dip;
        logic [15:0] dport;
        logic [15:0] plen;
        logic [15:0] ulen;
        logic        u;
        int          kind;
        int          npad;
        int          avail;

        repeat (3) @(posedge gtx_clk);
        #3 glbl_rst = 1'b0;
        #1 check_reset_state();

        // leave SYNC with a lone tlast beat
        beat(8'h00, 1'b1, 1'b0);
        idle(4);
        check("sync_exit_good", 64'(good_cnt), 64'd0);
        check("sync_exit_drop", 64'(drop_cnt), 64'd0);

        // good frame, DE AD BE EF, 14 bytes padding
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 16'd12, 14, 32'hC0A80155, 16'd1234);
        send_frame(0, 1'b0);
        check("tlast_latency", 64'(t_out - t_in), 64'd11);

        // wrong port, then a good frame
        set_pay_random(6);
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'd5001, 16'd14, 10, 32'h0A000001, 16'd77);
        send_frame(0, 1'b0);
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 16'd14, 10, 32'h0A000001, 16'd77);
        send_frame(0, 1'b0);

        // bad FCS
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 16'd12, 14, 32'hC0A80155, 16'd1234);
        send_frame(0, 1'b1);

        // truncated: UDP len 108 but only 50 payload bytes
        set_pay_random(50);
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 16'd108, 0, 32'hC0A80109, 16'd4000);
        send_frame(0, 1'b0);

        // header runt: tlast on byte 20
        set_pay_random(4);
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 16'd12, 14, 32'hC0A80155, 16'd1234);
        while (frm.size() > 21) void'(frm.pop_back());
        send_frame(0, 1'b0);

        // reset at byte 25, remainder discarded in SYNC
        set_pay_random(8);
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 16'd16, 4, 32'hC0A80177, 16'd999);
        for (int i = 0; i < 25; i++) beat(frm[i], 1'b0, 1'b0);
        idle(1);
        #2 glbl_rst = 1'b1;
        @(posedge gtx_clk);
        #3 glbl_rst = 1'b0;
        exp_q.delete();
        hdr_q.delete();
        good_exp = 0;
        drop_exp = 0;
        #1 check_reset_state();
        for (int i = 25; i < frm.size(); i++) beat(frm[i], i == frm.size() - 1, 1'b0);
        idle(6);
        check("sync_discard_good", 64'(good_cnt), 64'd0);
        check("sync_discard_drop", 64'(drop_cnt), 64'd0);
        send_frame(0, 1'b0);

        // gapped tvalid on the good frame
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 16'd12, 14, 32'hC0A80155, 16'd1234);
        send_frame(1, 1'b0);

`ifdef UDP_RX_IP_CSUM_CHECK_EN
        // corrupted IP checksum byte
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 16'd12, 14, 32'hC0A80155, 16'd1234);
        frm[25] = frm[25] ^ 8'h01;
        send_frame(0, 1'b0);
`endif

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            kind  = $urandom_range(0, 9);
            plen  = 16'($urandom_range(2, 40));
            npad  = $urandom_range(0, 20);
            dmac  = LOCAL_MAC;
            etype = 16'h0800;
            dip   = LOCAL_IP;
            dport = LOCAL_PORT;
            u     = 1'b0;
            case (kind)
                1: dmac  = 48'hFFFF_FFFF_FFFF;
                2: dmac  = LOCAL_MAC ^ 48'h0000_0000_0100;
                3: dip   = LOCAL_IP ^ 32'h0000_0001;
                4: etype = 16'h86DD;
                7: plen  = 16'd0;
                8: npad  = 0;
                default: ;
            endcase
            if (kind == 0 || kind == 8) u = 1'($urandom_range(0, 1));
            ulen = (kind == 9) ? 16'd4 : plen + 16'd8;
            set_pay_random(int'(plen));
            build_frame(dmac, etype, dip, dport, ulen, npad,
                        32'($urandom), 16'($urandom_range(0, 65535)));
            if (kind == 5) begin
                avail = $urandom_range(1, int'(plen) - 1);
                while (frm.size() > 42 + avail) void'(frm.pop_back());
            end
            if (kind == 6) begin
                avail = $urandom_range(1, 41);
                while (frm.size() > avail) void'(frm.pop_back());
            end
            send_frame(2, u);
        end

        idle(4);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("hdr_q_drained", 64'(hdr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
